// File: rtl/td4_pkg.sv
// Shared TD4 definitions: width, ALU mux selects, opcodes shared with the decoder,
// and the step-controller state encoding.
package td4_pkg;

    // Native TD4 data/address width.
    localparam int TD4_W = 4;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [3:0] {
        OP_ADD_A_IM = 4'b0000,
        OP_MOV_A_B  = 4'b0001,
        OP_IN_A     = 4'b0010,
        OP_MOV_A_IM = 4'b0011,
        OP_MOV_B_A  = 4'b0100,
        OP_ADD_B_IM = 4'b0101,
        OP_IN_B     = 4'b0110,
        OP_MOV_B_IM = 4'b0111,
        OP_OUT_B    = 4'b1001,
        OP_OUT_IM   = 4'b1011,
        OP_JNC_IM   = 4'b1110,
        OP_JMP_IM   = 4'b1111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ARM      = 2'b01,
        ST_WAIT_REL = 2'b10
    } step_state_t;

endpackage

// File: rtl/td4_step_ctrl.sv
// Run/single-step controller: synchronises run and step_req, debounces the step
// button and produces the per-instruction execute strobe.
module td4_step_ctrl
    import td4_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic step_req,
    output logic exec
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic run_p0, run_p1;
    logic step_p0, step_p1;
    step_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Synchroniser stages p0/p1 and the FSM/counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_p0  <= 1'b0;
            run_p1  <= 1'b0;
            step_p0 <= 1'b0;
            step_p1 <= 1'b0;
            state   <= ST_IDLE;
            cnt     <= '0;
        end else begin
            run_p0  <= run;
            run_p1  <= run_p0;
            step_p0 <= step_req;
            step_p1 <= step_p0;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // The one counter serves both press debounce (IDLE) and release debounce (WAIT_REL).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (!step_p1) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_ARM;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_ARM: begin
                state_nxt = ST_WAIT_REL;
                cnt_nxt   = '0;
            end
            ST_WAIT_REL: begin
                if (step_p1) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign exec = run_p1 | (state == ST_ARM);

endmodule

// File: rtl/td4_datapath.sv
// TD4 execution stage: A/B/OUT/PC registers, carry flag, ALU mux and adder.
// Optional jump-to-self halt detection is enabled by defining TD4_HALT_DETECT_EN.
module td4_datapath
    import td4_pkg::*;
#(
    parameter int W               = TD4_W,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] imm,
    input  logic [1:0]   mux_sel,
    input  logic         load_a_n,
    input  logic         load_b_n,
    input  logic         load_out_n,
    input  logic         load_pc_n,
    input  logic [W-1:0] in_port,
    input  logic         run,
    input  logic         step_req,
    output logic [W-1:0] pc,
    output logic         flag_c,
    output logic [W-1:0] out_port,
    output logic [W-1:0] reg_a,
    output logic [W-1:0] reg_b,
`ifdef TD4_HALT_DETECT_EN
    output logic         halted,
`endif
    output logic         exec
);

    function automatic logic [W:0] add_carry(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    logic [W-1:0] mux_out;
    logic [W-1:0] sum;
    logic         cout;
    logic         step_exec;

    always_comb begin
        mux_out = '0;
        unique case (mux_sel)
            SEL_A:    mux_out = reg_a;
            SEL_B:    mux_out = reg_b;
            SEL_IN:   mux_out = in_port;
            SEL_ZERO: mux_out = '0;
            default:  mux_out = '0;
        endcase
    end

    assign {cout, sum} = add_carry(mux_out, imm);

    td4_step_ctrl #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_ctrl (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .step_req (step_req),
        .exec     (step_exec)
    );

`ifdef TD4_HALT_DETECT_EN
    // A taken jump to its own address can never make progress, so freeze the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (exec && !load_pc_n && (sum == pc)) begin
            halted <= 1'b1;
        end
    end

    assign exec = step_exec & ~halted;
`else
    assign exec = step_exec;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a    <= '0;
            reg_b    <= '0;
            out_port <= '0;
            pc       <= '0;
            flag_c   <= 1'b0;
        end else if (exec) begin
            if (!load_a_n)   reg_a    <= sum;
            if (!load_b_n)   reg_b    <= sum;
            if (!load_out_n) out_port <= sum;
            pc     <= load_pc_n ? pc + W'(1) : sum;
            flag_c <= cout;
        end
    end

endmodule
